// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT    = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_RUN       = 2'd3
  } state_e;

  localparam int unsigned DEF_NUM_STAGES  = 3;
  localparam int unsigned DEF_LOCK_STABLE = 1024;
  localparam int unsigned DEF_STAGE_GAP   = 16;

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single level signal, async-cleared to 0.
module sync_2ff (
  input  logic clk,
  input  logic arstn,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds stage resets until PLL lock is stable, then releases
// them in ascending order spaced by STAGE_GAP; any abort re-asserts all stages.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES  = DEF_NUM_STAGES,
  parameter int unsigned LOCK_STABLE = DEF_LOCK_STABLE,
  parameter int unsigned STAGE_GAP   = DEF_STAGE_GAP
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  pll_locked,
  input  logic                  sw_rst_req,
  output logic [NUM_STAGES-1:0] rst_out,
  output logic                  rst_done
);

  localparam int unsigned CNT_W = clog2((LOCK_STABLE > STAGE_GAP) ? LOCK_STABLE : STAGE_GAP);
  localparam int unsigned IDX_W = clog2(NUM_STAGES + 1);

  localparam logic [CNT_W-1:0] GAP_TC   = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] LOCK_TC  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_STAGES-1:0] rst_out_q, rst_out_d;
  logic                  rst_done_q, rst_done_d;
  logic                  lock_s;
  logic                  abort;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .arstn (arstn),
    .d     (pll_locked),
    .q     (lock_s)
  );

  assign abort = !lock_s || sw_rst_req;

  // Next-state, shared counter and registered output decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    rst_out_d  = rst_out_q;
    rst_done_d = rst_done_q;

    unique case (state_q)
      ST_ASSERT: begin
        rst_out_d  = '1;
        rst_done_d = 1'b0;
        if (sw_rst_req) begin
          cnt_d = '0;
        end else if (cnt_q == GAP_TC) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_WAIT_LOCK: begin
        if (sw_rst_req) begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
        end else if (!lock_s) begin
          cnt_d = '0;
        end else if (cnt_q == LOCK_TC) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RELEASE: begin
        if (abort) begin
          state_d    = ST_ASSERT;
          cnt_d      = '0;
          idx_d      = '0;
          rst_out_d  = '1;
          rst_done_d = 1'b0;
        end else if (cnt_q == GAP_TC) begin
          cnt_d = '0;
          idx_d = idx_q + IDX_W'(1);
          for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            if (idx_q == IDX_W'(i)) rst_out_d[i] = 1'b0;
          end
          if (idx_q == LAST_IDX) begin
            state_d    = ST_RUN;
            rst_done_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RUN: begin
        if (abort) begin
          state_d    = ST_ASSERT;
          cnt_d      = '0;
          idx_d      = '0;
          rst_out_d  = '1;
          rst_done_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q    <= ST_ASSERT;
      cnt_q      <= '0;
      idx_q      <= '0;
      rst_out_q  <= '1;
      rst_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      rst_out_q  <= rst_out_d;
      rst_done_q <= rst_done_d;
    end
  end

  assign rst_out  = rst_out_q;
  assign rst_done = rst_done_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: a 3-stage and a 1-stage instance share
// stimulus; a phase/age reference model predicts outputs every cycle.
module tb_rst_seq_ctrl;

  localparam int GAP  = 4;
  localparam int LOCK = 8;
  localparam int NS_OF [2] = '{3, 1};

  typedef enum int {P_HOLD, P_WAIT, P_REL, P_RUN} phase_t;
  typedef struct packed {
    logic [2:0] ro;
    logic       done;
  } exp_t;

  logic       clk;
  logic       arstn;
  logic       pll_locked;
  logic       sw_rst_req;
  logic [2:0] rst_out0;
  logic       rst_done0;
  logic [0:0] rst_out1;
  logic       rst_done1;

  int tests;
  int errors;

  rst_seq_ctrl #(.NUM_STAGES(3), .LOCK_STABLE(LOCK), .STAGE_GAP(GAP)) u_dut3 (
    .clk        (clk),
    .arstn      (arstn),
    .pll_locked (pll_locked),
    .sw_rst_req (sw_rst_req),
    .rst_out    (rst_out0),
    .rst_done   (rst_done0)
  );

  rst_seq_ctrl #(.NUM_STAGES(1), .LOCK_STABLE(LOCK), .STAGE_GAP(GAP)) u_dut1 (
    .clk        (clk),
    .arstn      (arstn),
    .pll_locked (pll_locked),
    .sw_rst_req (sw_rst_req),
    .rst_out    (rst_out1),
    .rst_done   (rst_done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  phase_t ph [2];
  int     age [2];
  bit     lk1, lk2, ls;
  exp_t   q0 [$];
  exp_t   q1 [$];

  function automatic exp_t expect_of(input phase_t p, input int a);
    exp_t e;
    int   released;
    e.ro   = 3'b111;
    e.done = 1'b0;
    if (p == P_REL) begin
      released = a / GAP;
      for (int i = 0; i < 3; i++) e.ro[i] = (i >= released);
    end else if (p == P_RUN) begin
      e.ro   = 3'b000;
      e.done = 1'b1;
    end
    return e;
  endfunction

  always @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      lk1 = 1'b0;
      lk2 = 1'b0;
      for (int k = 0; k < 2; k++) begin
        ph[k]  = P_HOLD;
        age[k] = 0;
      end
      q0.delete();
      q1.delete();
      q0.push_back(expect_of(P_HOLD, 0));
      q1.push_back(expect_of(P_HOLD, 0));
    end else begin
      ls = lk2;
      for (int k = 0; k < 2; k++) begin
        case (ph[k])
          P_HOLD: begin
            if (sw_rst_req) age[k] = 0;
            else if (age[k] == GAP - 1) begin ph[k] = P_WAIT; age[k] = 0; end
            else age[k]++;
          end
          P_WAIT: begin
            if (sw_rst_req) begin ph[k] = P_HOLD; age[k] = 0; end
            else if (!ls) age[k] = 0;
            else if (age[k] == LOCK - 1) begin ph[k] = P_REL; age[k] = 0; end
            else age[k]++;
          end
          P_REL: begin
            if (!ls || sw_rst_req) begin ph[k] = P_HOLD; age[k] = 0; end
            else begin
              age[k]++;
              if (age[k] == GAP * NS_OF[k]) ph[k] = P_RUN;
            end
          end
          default: begin
            if (!ls || sw_rst_req) begin ph[k] = P_HOLD; age[k] = 0; end
          end
        endcase
      end
      lk2 = lk1;
      lk1 = pll_locked;
      q0.push_back(expect_of(ph[0], age[0]));
      q1.push_back(expect_of(ph[1], age[1]));
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      tests++;
      if ({rst_out0, rst_done0} !== {e.ro, e.done}) begin
        errors++;
        $display("FAIL sb_stage3 t=%0t: got rst_out=%b done=%b, expected rst_out=%b done=%b",
                 $time, rst_out0, rst_done0, e.ro, e.done);
      end
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      tests++;
      if ({rst_out1, rst_done1} !== {e.ro[0], e.done}) begin
        errors++;
        $display("FAIL sb_stage1 t=%0t: got rst_out=%b done=%b, expected rst_out=%b done=%b",
                 $time, rst_out1, rst_done1, e.ro[0], e.done);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  // Called at a negedge: async pulse between edges, release at the next negedge.
  task automatic pulse_arst();
    #2 arstn = 1'b0;
    #1;
    check("arst_out3", 32'(rst_out0), 32'd7);
    check("arst_done3", 32'(rst_done0), 32'd0);
    check("arst_out1", 32'(rst_out1), 32'd1);
    @(negedge clk);
    arstn = 1'b1;
  endtask

  task automatic wait_out0(input logic [2:0] v, input string nm);
    int n;
    n = 0;
    while (rst_out0 !== v && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (rst_out0 !== v) begin
      tests++;
      errors++;
      $display("FAIL %s: timeout, rst_out=%b, expected %b", nm, rst_out0, v);
    end
  endtask

  // Counts edges after release; records when stage 0/1 and done change.
  task automatic edge_profile(input int drop_at, output int f0, output int f1, output int fd);
    int e;
    f0 = 0; f1 = 0; fd = 0;
    for (e = 1; e <= 60; e++) begin
      @(negedge clk);
      if (e == drop_at) pll_locked = 1'b0;
      else pll_locked = 1'b1;
      if (f0 == 0 && rst_out0[0] === 1'b0) f0 = e;
      if (f1 == 0 && rst_out0[1] === 1'b0) f1 = e;
      if (fd == 0 && rst_done0 === 1'b1) fd = e;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int f0, f1, fd;
    tests      = 0;
    errors     = 0;
    arstn      = 1'b1;
    pll_locked = 1'b1;
    sw_rst_req = 1'b0;

    #1 arstn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_out3", 32'(rst_out0), 32'd7);
    check("reset_done3", 32'(rst_done0), 32'd0);

    // Clean start with lock held high.
    arstn = 1'b1;
    edge_profile(0, f0, f1, fd);
    check("rel0_edge", 32'(f0), 32'd16);
    check("rel1_edge", 32'(f1), 32'd20);
    check("done_edge", 32'(fd), 32'd24);

    // Lock glitch after 5 counted lock cycles delays every release by 8.
    pulse_arst();
    edge_profile(9, f0, f1, fd);
    check("glitch_rel0_edge", 32'(f0), 32'd24);
    check("glitch_done_edge", 32'(fd), 32'd32);

    // Loss of lock in RUN, then recovery.
    repeat (5) @(negedge clk);
    pll_locked = 1'b0;
    repeat (3) @(negedge clk);
    check("lockloss_out3", 32'(rst_out0), 32'd7);
    check("lockloss_done3", 32'(rst_done0), 32'd0);
    pll_locked = 1'b1;
    wait_out0(3'b000, "relock_done");

    // Software reset coincident with the first terminal count (edge 16).
    @(negedge clk);
    pulse_arst();
    for (int e = 1; e <= 16; e++) begin
      @(negedge clk);
      sw_rst_req = (e == 15);
    end
    check("coinc_out1", 32'(rst_out1), 32'd1);
    check("coinc_done1", 32'(rst_done1), 32'd0);
    check("coinc_out3", 32'(rst_out0), 32'd7);

    // Software reset in RELEASE with stage 0 already released.
    wait_out0(3'b110, "reach_110_sw");
    sw_rst_req = 1'b1;
    @(negedge clk);
    sw_rst_req = 1'b0;
    check("sw_out3", 32'(rst_out0), 32'd7);
    wait_out0(3'b000, "sw_redone");

    // Async reset mid-RELEASE.
    pulse_arst();
    wait_out0(3'b110, "reach_110_arst");
    pulse_arst();
    wait_out0(3'b000, "arst_redone");

    // Randomized lock glitches and software requests.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      pll_locked = ($urandom_range(0, 99) >= 3);
      sw_rst_req = ($urandom_range(0, 249) == 0);
    end
    pll_locked = 1'b1;
    sw_rst_req = 1'b0;
    wait_out0(3'b000, "final_done");
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
